// File: rtl/fifo_pkg.sv
// Shared types and helpers for the programmable synchronous FIFO.
// The count/threshold width holds the values 0..depth inclusive.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Single-clock FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; the owning FIFO tracks validity through its pointers and count.
module fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Parametrised synchronous FIFO with arbitrary depth, STD or FWFT read mode,
// occupancy count and programmable full/empty thresholds.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int         FIFO_WIDTH = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter fifo_mode_e MODE       = FIFO_STD,
  localparam int        CNT_W      = cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [CNT_W-1:0]      prog_full_thresh,
  input  logic [CNT_W-1:0]      prog_empty_thresh,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic                  prog_full,
  output logic                  prog_empty,
  output logic [CNT_W-1:0]      data_count
);

  localparam int               AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0]    LAST_PTR  = AW'(FIFO_DEPTH - 1);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(FIFO_DEPTH - 1);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [FIFO_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc_s, rd_acc_s;
  logic [FIFO_WIDTH-1:0] mem_rdata_s;

  fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata_s)
  );

  assign full        = (count_q == CNT_FULL);
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q == CNT_AFULL);
  assign almostempty = (count_q == CNT_ONE);
  assign prog_full   = (count_q >= prog_full_thresh);
  assign prog_empty  = (count_q <= prog_empty_thresh);
  assign data_count  = count_q;
  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  // FWFT exposes the head word directly; STD presents the word popped at the last accepted read.
  assign data_out = (MODE == FIFO_FWFT) ? mem_rdata_s : dout_q;

  // Acceptance from pre-edge flags; requests during reset are ignored entirely.
  always_comb begin
    wr_acc_s    = rst_n & wr_en & ~full;
    rd_acc_s    = rst_n & rd_en & ~empty;
    wr_ack_d    = wr_acc_s;
    overflow_d  = rst_n & wr_en & full;
    underflow_d = rst_n & rd_en & empty;

    wr_ptr_d = wr_ptr_q;
    if (wr_acc_s) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : (wr_ptr_q + PTR_ONE);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    if (rd_acc_s) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : (rd_ptr_q + PTR_ONE);
      dout_d   = mem_rdata_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
      dout_d   = dout_q;
    end

    count_d = count_q;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog: DEPTH=8 STD, DEPTH=5 STD and DEPTH=8 FWFT instances.
module tb_sync_fifo_prog;
  import fifo_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // instance a: DEPTH 8, STD
  logic [15:0] din_a, dout_a;
  logic        wr_a, rd_a, ack_a, ovf_a, udf_a, full_a, empty_a, af_a, ae_a, pf_a, pe_a;
  logic [3:0]  pft_a, pet_a, cnt_a;
  // instance b: DEPTH 5, STD
  logic [15:0] din_b, dout_b;
  logic        wr_b, rd_b, ack_b, ovf_b, udf_b, full_b, empty_b, af_b, ae_b, pf_b, pe_b;
  logic [2:0]  pft_b, pet_b, cnt_b;
  // instance c: DEPTH 8, FWFT
  logic [15:0] din_c, dout_c;
  logic        wr_c, rd_c, ack_c, ovf_c, udf_c, full_c, empty_c, af_c, ae_c, pf_c, pe_c;
  logic [3:0]  pft_c, pet_c, cnt_c;

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .MODE(FIFO_STD)) u_a (
    .clk(clk), .rst_n(rst_n), .data_in(din_a), .wr_en(wr_a), .rd_en(rd_a),
    .prog_full_thresh(pft_a), .prog_empty_thresh(pet_a), .data_out(dout_a),
    .wr_ack(ack_a), .overflow(ovf_a), .underflow(udf_a), .full(full_a), .empty(empty_a),
    .almostfull(af_a), .almostempty(ae_a), .prog_full(pf_a), .prog_empty(pe_a),
    .data_count(cnt_a));

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .MODE(FIFO_STD)) u_b (
    .clk(clk), .rst_n(rst_n), .data_in(din_b), .wr_en(wr_b), .rd_en(rd_b),
    .prog_full_thresh(pft_b), .prog_empty_thresh(pet_b), .data_out(dout_b),
    .wr_ack(ack_b), .overflow(ovf_b), .underflow(udf_b), .full(full_b), .empty(empty_b),
    .almostfull(af_b), .almostempty(ae_b), .prog_full(pf_b), .prog_empty(pe_b),
    .data_count(cnt_b));

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .MODE(FIFO_FWFT)) u_c (
    .clk(clk), .rst_n(rst_n), .data_in(din_c), .wr_en(wr_c), .rd_en(rd_c),
    .prog_full_thresh(pft_c), .prog_empty_thresh(pet_c), .data_out(dout_c),
    .wr_ack(ack_c), .overflow(ovf_c), .underflow(udf_c), .full(full_c), .empty(empty_c),
    .almostfull(af_c), .almostempty(ae_c), .prog_full(pf_c), .prog_empty(pe_c),
    .data_count(cnt_c));

  // Scoreboard: stimulus pushes the expected word when it issues a read that must be accepted
  logic [15:0] exp_a[$], exp_b[$], exp_c[$];
  logic        sb_a = 1'b0, sb_b = 1'b0, sb_c = 1'b0;
  logic        take_a, take_b;
  logic [15:0] e_a, e_b, e_c;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_miss(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: output presented with no expected word queued", name);
  endtask

  // STD monitors: data_out is valid shortly after the edge that accepted the read
  always @(posedge clk) begin
    take_a = sb_a;
    take_b = sb_b;
    #2;
    if (take_a) begin
      if (exp_a.size() == 0) sb_miss("a_rd_data");
      else begin
        e_a = exp_a.pop_front();
        chk("a_rd_data", 32'(dout_a), 32'(e_a));
      end
    end
    if (take_b) begin
      if (exp_b.size() == 0) sb_miss("b_rd_data");
      else begin
        e_b = exp_b.pop_front();
        chk("b_rd_data", 32'(dout_b), 32'(e_b));
      end
    end
  end

  // FWFT monitor: head word is on data_out during the cycle that pops it
  always @(negedge clk) begin
    if (sb_c) begin
      if (exp_c.size() == 0) sb_miss("c_head");
      else begin
        e_c = exp_c.pop_front();
        chk("c_head", 32'(dout_c), 32'(e_c));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_a = 1'b0; rd_a = 1'b0; sb_a = 1'b0;
    wr_b = 1'b0; rd_b = 1'b0; sb_b = 1'b0;
    wr_c = 1'b0; rd_c = 1'b0; sb_c = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    din_a = 16'h0000; din_b = 16'h0000; din_c = 16'h0000;
    pft_a = 4'd6; pet_a = 4'd2;
    pft_b = 3'd4; pet_b = 3'd1;
    pft_c = 4'd6; pet_c = 4'd2;
    step();
    step();
    chk("rst_count", 32'(cnt_a), 32'd0);
    chk("rst_empty", 32'(empty_a), 32'd1);
    chk("rst_full", 32'(full_a), 32'd0);
    chk("rst_dout", 32'(dout_a), 32'd0);
    chk("rst_flags", 32'({ack_a, ovf_a, udf_a}), 32'd0);
    chk("rst_prog", 32'({pf_a, pe_a}), 32'b01);
    rst_n = 1'b1;

    // fill to full
    for (int i = 1; i <= 8; i++) begin
      idle(); wr_a = 1'b1; din_a = 16'(i);
      step();
      chk("fill_ack", 32'(ack_a), 32'd1);
      chk("fill_count", 32'(cnt_a), 32'(i));
      chk("fill_afull", 32'(af_a), 32'(i == 7));
      chk("fill_full", 32'(full_a), 32'(i == 8));
      chk("fill_pfull", 32'(pf_a), 32'(i >= 6));
      chk("fill_pempty", 32'(pe_a), 32'(i <= 2));
      chk("fill_aempty", 32'(ae_a), 32'(i == 1));
    end
    idle(); wr_a = 1'b1; din_a = 16'h00EE;
    step();
    chk("ovf_flag", 32'({ack_a, ovf_a}), 32'b01);
    chk("ovf_count", 32'(cnt_a), 32'd8);

    // drain
    for (int i = 1; i <= 8; i++) begin
      idle(); rd_a = 1'b1; sb_a = 1'b1; exp_a.push_back(16'(i));
      step();
      chk("drain_count", 32'(cnt_a), 32'(8 - i));
      chk("drain_empty", 32'(empty_a), 32'(i == 8));
      chk("drain_pempty", 32'(pe_a), 32'((8 - i) <= 2));
      chk("drain_pfull", 32'(pf_a), 32'((8 - i) >= 6));
      chk("drain_flags", 32'({ovf_a, udf_a}), 32'd0);
    end
    idle(); rd_a = 1'b1;
    step();
    chk("udf_flag", 32'(udf_a), 32'd1);
    chk("udf_dout_hold", 32'(dout_a), 32'h0008);
    chk("udf_count", 32'(cnt_a), 32'd0);

    // simultaneous on empty: write only
    idle(); wr_a = 1'b1; rd_a = 1'b1; din_a = 16'h0055;
    step();
    chk("both_empty_flags", 32'({ack_a, ovf_a, udf_a}), 32'b101);
    chk("both_empty_count", 32'(cnt_a), 32'd1);
    for (int i = 0; i < 7; i++) begin
      idle(); wr_a = 1'b1; din_a = 16'h0056 + 16'(i);
      step();
    end
    idle();
    step();
    chk("refill_count", 32'(cnt_a), 32'd8);
    chk("single_cycle_ack", 32'(ack_a), 32'd0);

    // simultaneous on full: read only
    idle(); wr_a = 1'b1; rd_a = 1'b1; din_a = 16'h00EE;
    sb_a = 1'b1; exp_a.push_back(16'h0055);
    step();
    chk("both_full_flags", 32'({ack_a, ovf_a, udf_a}), 32'b010);
    chk("both_full_count", 32'(cnt_a), 32'd7);
    idle(); rd_a = 1'b1; sb_a = 1'b1; exp_a.push_back(16'h0056);
    step();
    idle(); rd_a = 1'b1; sb_a = 1'b1; exp_a.push_back(16'h0057);
    step();
    chk("mid_count", 32'(cnt_a), 32'd5);
    chk("mid_prog", 32'({pf_a, pe_a}), 32'b00);

    // reset mid-operation with requests present
    idle(); rst_n = 1'b0; wr_a = 1'b1; rd_a = 1'b1; din_a = 16'h00EE;
    step();
    chk("midrst_count", 32'(cnt_a), 32'd0);
    chk("midrst_empty", 32'(empty_a), 32'd1);
    chk("midrst_flags", 32'({ack_a, ovf_a, udf_a}), 32'd0);
    chk("midrst_dout", 32'(dout_a), 32'd0);
    rst_n = 1'b1;
    idle(); wr_a = 1'b1; din_a = 16'h0777;
    step();
    idle(); rd_a = 1'b1; sb_a = 1'b1; exp_a.push_back(16'h0777);
    step();
    chk("post_rst_count", 32'(cnt_a), 32'd0);

    // DEPTH 5: alternating write/read through two pointer wraps
    for (int i = 0; i < 12; i++) begin
      idle(); wr_b = 1'b1; din_b = 16'hA000 + 16'(i);
      step();
      chk("d5_count_w", 32'(cnt_b), 32'd1);
      idle(); rd_b = 1'b1; sb_b = 1'b1; exp_b.push_back(16'hA000 + 16'(i));
      step();
      chk("d5_count_r", 32'(cnt_b), 32'd0);
    end

    // FWFT
    idle(); wr_c = 1'b1; din_c = 16'h1234;
    step();
    chk("fwft_head", 32'(dout_c), 32'h1234);
    chk("fwft_empty", 32'(empty_c), 32'd0);
    idle();
    step();
    chk("fwft_hold", 32'(dout_c), 32'h1234);
    chk("fwft_ack_once", 32'(ack_c), 32'd0);
    idle(); wr_c = 1'b1; din_c = 16'h5678;
    step();
    chk("fwft_head2", 32'(dout_c), 32'h1234);
    chk("fwft_count", 32'(cnt_c), 32'd2);
    idle(); rd_c = 1'b1; sb_c = 1'b1; exp_c.push_back(16'h1234);
    step();
    chk("fwft_next", 32'(dout_c), 32'h5678);
    idle(); rd_c = 1'b1; sb_c = 1'b1; exp_c.push_back(16'h5678);
    step();
    chk("fwft_empty_end", 32'(empty_c), 32'd1);

    idle();
    step();
    step();
    chk("sb_a_drained", 32'(exp_a.size()), 32'd0);
    chk("sb_b_drained", 32'(exp_b.size()), 32'd0);
    chk("sb_c_drained", 32'(exp_c.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Parametrised synchronous FIFO, the successor to the fixed 16×8 FIFO. It adds arbitrary (non-power-of-two) depth, a first-word-fall-through (FWFT) read mode, an occupancy count, and programmable full/empty thresholds. It sits between a producer and a consumer in the same clock domain. The existing verification interfaces drive and observe it, extended with the new ports.

## Interface
Parameters:
- FIFO_WIDTH, 16, data word width (≥1)
- FIFO_DEPTH, 8, number of words (≥2, any integer)
- MODE, FIFO_STD, read mode: FIFO_STD (registered read) or FIFO_FWFT
- CNT_W, $clog2(FIFO_DEPTH+1), width of count and threshold buses (derived, not overridden)

Ports (one clock; reset is synchronous and active-low):
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- data_in  input  FIFO_WIDTH  write data
- wr_en  input  1  write request
- rd_en  input  1  read request
- prog_full_thresh  input  CNT_W  programmable-full level
- prog_empty_thresh  input  CNT_W  programmable-empty level
- data_out  output  FIFO_WIDTH  read data
- wr_ack  output  1  registered; previous-cycle write accepted
- overflow  output  1  registered; previous-cycle write rejected (full)
- underflow  output  1  registered; previous-cycle read rejected (empty)
- full, empty, almostfull, almostempty  output  1  combinational from count
- prog_full, prog_empty  output  1  combinational threshold flags
- data_count  output  CNT_W  current occupancy, 0..FIFO_DEPTH

## Operation
- Acceptance uses pre-edge state only: write accepted iff wr_en && !full; read accepted iff rd_en && !empty.
- Simultaneous wr_en and rd_en:
  - When neither full nor empty: both accepted, count unchanged.
  - When full: read only, overflow=1.
  - When empty: write only, underflow=1.
- Flags:
  - full = (count==FIFO_DEPTH); empty = (count==0)
  - almostfull = (count==FIFO_DEPTH-1); almostempty = (count==1)
  - prog_full = (count ≥ prog_full_thresh); prog_empty = (count ≤ prog_empty_thresh)
  - Thresholds are sampled live; there is no range check.
- Pointers wr_ptr/rd_ptr are 0..FIFO_DEPTH-1 and wrap explicitly from FIFO_DEPTH-1 to 0. No power-of-two assumption.
- Count: +1 on accepted write only, −1 on accepted read only, unchanged otherwise. It never exceeds FIFO_DEPTH or goes below 0.
- Rejected operations never modify memory, pointers or count.
- FIFO_STD: data_out is registered and updated only on an accepted read. Otherwise it holds its last value.
- FIFO_FWFT: data_out = mem[rd_ptr] whenever !empty, so the head word is visible without rd_en; rd_en pops it. data_out is don't-care while empty; the bench must not check it.
- Reset (rst_n low at an edge):
  - pointers and count 0
  - wr_ack/overflow/underflow 0
  - data_out 0 in FIFO_STD
  - empty=1, full=0; prog_* follow the thresholds
  - memory contents not cleared
- Reset asserted mid-operation discards all stored words. Requests in the reset cycle are ignored and raise no wr_ack/overflow/underflow.

## Timing
- Write → visible in count/flags: the cycle after the accepting edge.
- FIFO_STD read latency: 1 cycle (data_out valid after the edge at which rd_en was accepted).
- FIFO_FWFT: 0-cycle latency. A word written into an empty FIFO appears on data_out the cycle after the write edge.
- wr_ack/overflow/underflow: registered and asserted for exactly one cycle per request, in the cycle after the request.
- No combinational path from wr_en/rd_en to any output.

## Structure
- Package fifo_pkg: typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT}; function cnt_width(depth) returning $clog2(depth+1).
- Sub-module fifo_mem: single-clock RAM, one write port and one asynchronous read port (FIFO_WIDTH × FIFO_DEPTH). The top holds the pointers, count, flags and the MODE-dependent output register.

## Test plan
- Reset then 8 writes 0x0001..0x0008 (DEPTH=8) → wr_ack each cycle; count 1..8; almostfull at 7; full at 8. A 9th write → overflow=1, count stays 8.
- Drain 8 reads (STD) → data_out 0x0001..0x0008, each one cycle after its read; empty at 0. A 9th read → underflow=1, data_out holds 0x0008.
- DEPTH=5, 12 write/read pairs with data 0xA000+i → outputs in order through two pointer wraps; count never exceeds 1.
- Full (DEPTH=8) with wr_en and rd_en together → read accepted, overflow=1, count 7. Empty with both → write accepted, underflow=1, count 1.
- FWFT: write 0x1234 into empty → data_out=0x1234 next cycle with no rd_en; rd_en → empty=1.
- prog_full_thresh=6, prog_empty_thresh=2 → prog_empty high at counts 0..2, prog_full high at 6..8. Assert rst_n=0 at count 5 → count 0, empty=1 the next cycle.
